// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: scan-out reads first, queued pixel writes second,
// full-frame fill engine on whatever slots are left.
module vga_fb_arbiter #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter int unsigned DW         = 24,
   parameter int unsigned AW         = 19,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic [9:0]    h_addr,
   input  logic [9:0]    v_addr,
   input  logic          valid,
   output logic [DW-1:0] vga_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [9:0]    wr_x,
   input  logic [9:0]    wr_y,
   input  logic [DW-1:0] wr_data,
   input  logic          fill_start,
   input  logic [DW-1:0] fill_color,
   output logic          fill_busy,
   output logic          wr_drop,
   input  logic          drop_clr,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned WW       = AW + 11;
   localparam logic [AW-1:0] LastPix = AW'(H_RES * V_RES - 1);
   localparam logic [9:0]    HLim    = 10'(H_RES);
   localparam logic [9:0]    VLim    = 10'(V_RES);
   localparam logic [PW:0]   FullCnt = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StPend, StFill} fill_state_e;

   // Linear pixel address; the 640-wide case avoids a multiplier.
   function automatic logic [AW-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
      logic [WW-1:0] yw;
      logic [WW-1:0] xw;
      logic [WW-1:0] sum;
      yw = WW'(y);
      xw = WW'(x);
      if (H_RES == 640) sum = (yw << 9) + (yw << 7) + xw;
      else              sum = yw * WW'(H_RES) + xw;
      return sum[AW-1:0];
   endfunction

   fill_state_e   state_q, state_d;
   logic [AW-1:0] fill_ptr_q, fill_ptr_d;
   logic [DW-1:0] fill_color_q, fill_color_d;
   logic          drop_q, drop_d;
   logic          rd_d1_q;

   logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;

   logic fifo_empty, fifo_full, in_range, accept, push, pop, fill_adv;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FullCnt);
   assign wr_ready   = reset & ~fifo_full & (state_q == StIdle);
   assign in_range   = (wr_x < HLim) && (wr_y < VLim);
   assign accept     = wr_valid & wr_ready;
   // Out-of-range requests complete the handshake but never reach the RAM.
   assign push       = accept & in_range;
   assign fill_busy  = (state_q != StIdle);
   assign wr_drop    = drop_q;
   assign vga_data   = rd_d1_q ? mem_rdata : '0;

   // Slot arbitration: scan-out read, then FIFO head, then fill pixel.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      pop       = 1'b0;
      fill_adv  = 1'b0;
      if (valid) begin
         mem_addr = pix_addr(h_addr, v_addr);
      end else if (!fifo_empty) begin
         pop       = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = fifo_addr_q[rd_ptr_q];
         mem_wdata = fifo_data_q[rd_ptr_q];
      end else if (state_q == StFill) begin
         fill_adv  = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = fill_ptr_q;
         mem_wdata = fill_color_q;
      end
   end

   // Fill FSM next state; PEND waits for queued writes so the fill lands last.
   always_comb begin
      state_d      = state_q;
      fill_ptr_d   = fill_ptr_q;
      fill_color_d = fill_color_q;
      case (state_q)
         StIdle: begin
            if (fill_start) begin
               state_d      = StPend;
               fill_color_d = fill_color;
            end
         end
         StPend: begin
            if (fifo_empty) begin
               state_d    = StFill;
               fill_ptr_d = '0;
            end
         end
         StFill: begin
            if (fill_adv) begin
               if (fill_ptr_q == LastPix) state_d = StIdle;
               else                       fill_ptr_d = fill_ptr_q + AW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO occupancy and sticky drop flag; clear beats a same-cycle drop.
   always_comb begin
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
      drop_d = drop_q;
      if (drop_clr)                drop_d = 1'b0;
      else if (accept && !in_range) drop_d = 1'b1;
   end

   // Control state registers.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         fill_ptr_q   <= '0;
         fill_color_q <= '0;
         drop_q       <= 1'b0;
         rd_d1_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         fill_ptr_q   <= fill_ptr_d;
         fill_color_q <= fill_color_d;
         drop_q       <= drop_d;
         rd_d1_q      <= valid;
         count_q      <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // FIFO storage; contents are don't-care while the entry is unoccupied.
   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= pix_addr(wr_x, wr_y);
         fifo_data_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench: full-size arbiter for addressing/contention, small frame for the fill.
module tb_vga_fb_arbiter;

   logic        pclk;
   logic        reset;
   int          checks;
   int          errors;

   // Full-size instance signals
   logic [9:0]  h_addr, v_addr, wr_x, wr_y;
   logic        valid, wr_valid, wr_ready, fill_start, fill_busy, wr_drop, drop_clr, mem_we;
   logic [23:0] vga_data, wr_data, fill_color, mem_wdata, mem_rdata;
   logic [18:0] mem_addr;

   // Small-frame instance signals (8x4 frame)
   logic [9:0]  h_addr_s, v_addr_s, wr_x_s, wr_y_s;
   logic        valid_s, wr_valid_s, wr_ready_s, fill_start_s, fill_busy_s, wr_drop_s;
   logic        drop_clr_s, mem_we_s;
   logic [23:0] vga_data_s, wr_data_s, fill_color_s, mem_wdata_s, mem_rdata_s;
   logic [4:0]  mem_addr_s;

   logic [23:0] ram [0:307199];
   bit          wflag [0:307199];
   logic [23:0] ram_s [0:31];

   vga_fb_arbiter dut (
      .pclk(pclk), .reset(reset), .h_addr(h_addr), .v_addr(v_addr), .valid(valid),
      .vga_data(vga_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
      .wr_y(wr_y), .wr_data(wr_data), .fill_start(fill_start), .fill_color(fill_color),
      .fill_busy(fill_busy), .wr_drop(wr_drop), .drop_clr(drop_clr), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   vga_fb_arbiter #(.H_RES(8), .V_RES(4), .DW(24), .AW(5), .FIFO_DEPTH(4)) dut_s (
      .pclk(pclk), .reset(reset), .h_addr(h_addr_s), .v_addr(v_addr_s), .valid(valid_s),
      .vga_data(vga_data_s), .wr_valid(wr_valid_s), .wr_ready(wr_ready_s), .wr_x(wr_x_s),
      .wr_y(wr_y_s), .wr_data(wr_data_s), .fill_start(fill_start_s),
      .fill_color(fill_color_s), .fill_busy(fill_busy_s), .wr_drop(wr_drop_s),
      .drop_clr(drop_clr_s), .mem_addr(mem_addr_s), .mem_we(mem_we_s),
      .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Synchronous RAM model; unwritten locations read back their own address.
   always @(posedge pclk) begin
      if (mem_we) begin
         ram[mem_addr]   <= mem_wdata;
         wflag[mem_addr] <= 1'b1;
      end
      mem_rdata <= wflag[mem_addr] ? ram[mem_addr] : 24'(mem_addr);
   end

   always @(posedge pclk) begin
      if (mem_we_s) ram_s[mem_addr_s] <= mem_wdata_s;
      mem_rdata_s <= ram_s[mem_addr_s];
   end

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) @(posedge pclk);
      #1;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset_fill_busy: got %b want 0", fill_busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (vga_data !== 24'h0) begin errors++; $display("FAIL reset_vga_data: got %h want 0", vga_data); end
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
      reset = 1'b1;
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready: got %b want 1", wr_ready); end
      checks++; if (wr_ready_s !== 1'b1) begin errors++; $display("FAIL release_wr_ready_s: got %b want 1", wr_ready_s); end
      @(posedge pclk); #1;
   endtask

   task automatic test_blank_write();
      valid = 1'b0; wr_valid = 1'b1; wr_x = 10'd3; wr_y = 10'd2; wr_data = 24'hFF0000;
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL blank_ready: got %b want 1", wr_ready); end
      @(posedge pclk); #1;
      wr_valid = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL blank_we: got %b want 1", mem_we); end
      checks++; if (mem_addr !== 19'd1283) begin errors++; $display("FAIL blank_addr: got %0d want 1283", mem_addr); end
      checks++; if (mem_wdata !== 24'hFF0000) begin errors++; $display("FAIL blank_wdata: got %h want ff0000", mem_wdata); end
      @(posedge pclk); #1;
      checks++; if (ram[1283] !== 24'hFF0000) begin errors++; $display("FAIL blank_ram: got %h want ff0000", ram[1283]); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL blank_we_after: got %b want 0", mem_we); end
   endtask

   task automatic test_contention();
      int idx;
      int we_seen;
      logic rdy;
      idx = 0; we_seen = 0;
      valid = 1'b1; h_addr = 10'd0; v_addr = 10'd0;
      wr_valid = 1'b1; wr_x = 10'd10; wr_y = 10'd5; wr_data = 24'hA0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (mem_we) we_seen++;
         rdy = wr_ready;
         @(posedge pclk); #1;
         if (rdy) idx++;
         wr_x = 10'(10 + idx); wr_data = 24'(8'hA0 + idx);
      end
      checks++; if (we_seen !== 0) begin errors++; $display("FAIL cont_we_while_valid: got %0d writes want 0", we_seen); end
      checks++; if (idx !== 4) begin errors++; $display("FAIL cont_accepted: got %0d want 4", idx); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_full: got %b want 0", wr_ready); end
      valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_we[%0d]: got %b want 1", k, mem_we); end
         checks++; if (mem_addr !== 19'(3210 + k)) begin errors++; $display("FAIL drain_addr[%0d]: got %0d want %0d", k, mem_addr, 3210 + k); end
         checks++; if (mem_wdata !== 24'(8'hA0 + k)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, mem_wdata, 8'hA0 + k); end
         rdy = wr_ready;
         @(posedge pclk); #1;
         if (rdy && idx < 5) begin
            idx++;
            if (idx == 5) wr_valid = 1'b0;
         end
      end
      wr_valid = 1'b0;
      checks++; if (idx !== 5) begin errors++; $display("FAIL cont_fifth_accepted: got %0d want 5", idx); end
      #1;
      checks++; if (mem_addr !== 19'd3214) begin errors++; $display("FAIL cont_fifth_addr: got %0d want 3214", mem_addr); end
      checks++; if (mem_wdata !== 24'hA4) begin errors++; $display("FAIL cont_fifth_data: got %h want a4", mem_wdata); end
      @(posedge pclk); #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL cont_empty_we: got %b want 0", mem_we); end
   endtask

   task automatic test_scanout();
      valid = 1'b1; h_addr = 10'd639; v_addr = 10'd479;
      #1;
      checks++; if (mem_addr !== 19'd307199) begin errors++; $display("FAIL scan_addr: got %0d want 307199", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL scan_we: got %b want 0", mem_we); end
      @(posedge pclk); #1;
      valid = 1'b0;
      #1;
      checks++; if (vga_data !== 24'd307199) begin errors++; $display("FAIL scan_data: got %0d want 307199", vga_data); end
      @(posedge pclk); #1;
      checks++; if (vga_data !== 24'd0) begin errors++; $display("FAIL scan_blank_data: got %0d want 0", vga_data); end
   endtask

   task automatic test_range();
      wr_valid = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 24'h123;
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL range_ready: got %b want 1", wr_ready); end
      @(posedge pclk); #1;
      wr_valid = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL range_we: got %b want 0", mem_we); end
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL range_drop: got %b want 1", wr_drop); end
      @(posedge pclk); #1;
      wr_valid = 1'b1; wr_x = 10'd5; wr_y = 10'd480; drop_clr = 1'b1;
      @(posedge pclk); #1;
      wr_valid = 1'b0; drop_clr = 1'b0;
      #1;
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL range_clr_priority: got %b want 0", wr_drop); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL range_y_we: got %b want 0", mem_we); end
      @(posedge pclk); #1;
      wr_valid = 1'b1; wr_x = 10'd0; wr_y = 10'd480;
      @(posedge pclk); #1;
      wr_valid = 1'b0;
      #1;
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL range_y_drop: got %b want 1", wr_drop); end
      @(posedge pclk); #1;
      drop_clr = 1'b1;
      @(posedge pclk); #1;
      drop_clr = 1'b0;
      #1;
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL range_clr: got %b want 0", wr_drop); end
      @(posedge pclk); #1;
   endtask

   task automatic test_fill();
      int wi;
      int cyc;
      bit pulsed;
      logic [4:0]  exp_a;
      logic [23:0] exp_d;
      valid_s = 1'b1;
      wr_valid_s = 1'b1; wr_x_s = 10'd1; wr_y_s = 10'd1; wr_data_s = 24'h111111;
      #1;
      checks++; if (wr_ready_s !== 1'b1) begin errors++; $display("FAIL fill_pre_ready: got %b want 1", wr_ready_s); end
      @(posedge pclk); #1;
      wr_x_s = 10'd2; wr_y_s = 10'd3; wr_data_s = 24'h222222;
      @(posedge pclk); #1;
      wr_valid_s = 1'b0; fill_start_s = 1'b1; fill_color_s = 24'h00FF00;
      @(posedge pclk); #1;
      fill_start_s = 1'b0; fill_color_s = 24'h0000FF;
      #1;
      checks++; if (fill_busy_s !== 1'b1) begin errors++; $display("FAIL fill_busy_pend: got %b want 1", fill_busy_s); end
      checks++; if (wr_ready_s !== 1'b0) begin errors++; $display("FAIL fill_ready_pend: got %b want 0", wr_ready_s); end
      repeat (3) @(posedge pclk);
      #1;
      checks++; if (mem_we_s !== 1'b0) begin errors++; $display("FAIL fill_we_valid: got %b want 0", mem_we_s); end
      wi = 0; cyc = 0; pulsed = 1'b0;
      while (fill_busy_s && cyc < 400) begin
         valid_s = (cyc % 3 == 0);
         fill_start_s = (wi == 10 && !pulsed);
         if (fill_start_s) pulsed = 1'b1;
         #1;
         if (mem_we_s) begin
            if (wi == 0)      begin exp_a = 5'd9;  exp_d = 24'h111111; end
            else if (wi == 1) begin exp_a = 5'd26; exp_d = 24'h222222; end
            else              begin exp_a = 5'(wi - 2); exp_d = 24'h00FF00; end
            checks++; if (valid_s !== 1'b0) begin errors++; $display("FAIL fill_we_during_valid[%0d]: got valid=1 want 0", wi); end
            checks++; if (mem_addr_s !== exp_a) begin errors++; $display("FAIL fill_addr[%0d]: got %0d want %0d", wi, mem_addr_s, exp_a); end
            checks++; if (mem_wdata_s !== exp_d) begin errors++; $display("FAIL fill_data[%0d]: got %h want %h", wi, mem_wdata_s, exp_d); end
            wi++;
         end
         @(posedge pclk); #1;
         cyc++;
      end
      fill_start_s = 1'b0; valid_s = 1'b0;
      checks++; if (cyc >= 400) begin errors++; $display("FAIL fill_timeout: got %0d cycles want <400", cyc); end
      checks++; if (wi !== 34) begin errors++; $display("FAIL fill_write_count: got %0d want 34", wi); end
      checks++; if (fill_busy_s !== 1'b0) begin errors++; $display("FAIL fill_busy_done: got %b want 0", fill_busy_s); end
      for (int a = 0; a < 32; a++) begin
         checks++; if (ram_s[a] !== 24'h00FF00) begin errors++; $display("FAIL fill_ram[%0d]: got %h want 00ff00", a, ram_s[a]); end
      end
      #1;
      checks++; if (mem_we_s !== 1'b0) begin errors++; $display("FAIL fill_idle_we: got %b want 0", mem_we_s); end
      checks++; if (wr_ready_s !== 1'b1) begin errors++; $display("FAIL fill_idle_ready: got %b want 1", wr_ready_s); end
   endtask

   initial begin
      checks = 0; errors = 0;
      reset = 1'b0;
      h_addr = '0; v_addr = '0; valid = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
      wr_data = '0; fill_start = 1'b0; fill_color = '0; drop_clr = 1'b0;
      h_addr_s = '0; v_addr_s = '0; valid_s = 1'b0; wr_valid_s = 1'b0; wr_x_s = '0;
      wr_y_s = '0; wr_data_s = '0; fill_start_s = 1'b0; fill_color_s = '0; drop_clr_s = 1'b0;
      test_reset();
      test_blank_write();
      test_contention();
      test_scanout();
      test_range();
      test_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
